// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Instruction memory that sits behind the core's fetch port. A byte-stream boot
// loader fills the memory (big-endian words) while the core is held in reset;
// once the image is complete the block releases the core and answers fetches
// combinationally.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   ce_i        fetch enable from the core
//   addr_i      fetch byte address from the core
//   inst_o      instruction word returned to the core (0 = nop when not served)
//   ld_valid_i  loader byte valid
//   ld_byte_i   loader byte
//   ld_last_i   final byte of the image (qualified by ld_valid_i)
//   ld_ready_o  block accepts a loader byte this cycle
//   reload_i    single-cycle request to go back to loading from RUN
//   cpu_hold_o  reset request to the core, high whenever not in RUN
//   ld_words_o  number of words written by the current load
//   addr_err_o  sticky out-of-range / misaligned fetch flag
// -----------------------------------------------------------------------------
module inst_rom_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic [31:0]   addr_i,
  output logic [31:0]   inst_o,
  input  logic          ld_valid_i,
  input  logic [7:0]    ld_byte_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  input  logic          reload_i,
  output logic          cpu_hold_o,
  output logic [AW:0]   ld_words_o,
  output logic          addr_err_o
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   WORDS_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_LAST  = {AW{1'b1}};

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_cnt;
  logic [1:0]      w_cnt_nxt;
  logic [AW-1:0]   r_ptr;
  logic [AW-1:0]   w_ptr_nxt;
  logic [23:0]     r_asm;        // first three bytes of the word in progress
  logic [23:0]     w_asm_nxt;
  logic [AW:0]     r_words;
  logic [AW:0]     w_words_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic [31:0]     r_mem [2**AW];

  logic            w_run;
  logic            w_acc;
  logic            w_wr;
  logic            w_full;
  logic            w_addr_ok;
  logic [31:0]     w_word;

  assign w_run      = (r_state == ST_RUN);
  // Ready is gated by rst so it reads low for the whole reset interval.
  assign ld_ready_o = rst & ~w_run;
  assign cpu_hold_o = ~w_run;
  assign ld_words_o = r_words;
  assign addr_err_o = r_err;

  assign w_acc  = ld_valid_i & ld_ready_o;
  // A word is committed on the 4th byte or on the last byte, never both twice.
  assign w_wr   = w_acc & ((r_cnt == 2'd3) | ld_last_i);
  assign w_full = w_wr & (r_ptr == PTR_LAST);

  assign w_addr_ok = (addr_i[31:AW+2] == {(30-AW){1'b0}}) && (addr_i[1:0] == 2'b00);

  // Word to commit: stored bytes, the incoming byte, zero padding below it.
  always_comb begin
    w_word = 32'h0000_0000;
    case (r_cnt)
      2'd0:    w_word = {ld_byte_i, 24'h00_0000};
      2'd1:    w_word = {r_asm[23:16], ld_byte_i, 16'h0000};
      2'd2:    w_word = {r_asm[23:8], ld_byte_i, 8'h00};
      2'd3:    w_word = {r_asm[23:0], ld_byte_i};
      default: w_word = 32'h0000_0000;
    endcase
  end

  // Next-state and loader/status datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_asm_nxt   = r_asm;
    w_words_nxt = r_words;
    w_err_nxt   = r_err;
    case (r_state)
      ST_LOAD: begin
        if (w_wr) begin
          w_cnt_nxt   = 2'd0;
          w_asm_nxt   = 24'h00_0000;
          w_words_nxt = r_words + WORDS_ONE;
          // The pointer parks on the last word instead of wrapping to 0.
          if (w_full) begin
            w_ptr_nxt = r_ptr;
          end else begin
            w_ptr_nxt = r_ptr + PTR_ONE;
          end
          if (ld_last_i || w_full) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else if (w_acc) begin
          w_cnt_nxt = r_cnt + 2'd1;
          case (r_cnt)
            2'd0:    w_asm_nxt[23:16] = ld_byte_i;
            2'd1:    w_asm_nxt[15:8]  = ld_byte_i;
            2'd2:    w_asm_nxt[7:0]   = ld_byte_i;
            default: w_asm_nxt        = r_asm;
          endcase
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_RUN: begin
        if (reload_i) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = 2'd0;
          w_ptr_nxt   = {AW{1'b0}};
          w_asm_nxt   = 24'h00_0000;
          w_words_nxt = {(AW+1){1'b0}};
          w_err_nxt   = 1'b0;
        end else if (ce_i && !w_addr_ok) begin
          w_err_nxt = 1'b1;
        end else begin
          w_err_nxt = r_err;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_cnt   <= 2'd0;
      r_ptr   <= {AW{1'b0}};
      r_asm   <= 24'h00_0000;
      r_words <= {(AW+1){1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_asm   <= w_asm_nxt;
      r_words <= w_words_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_ptr] <= w_word;
    end
  end

  // Combinational fetch so the core samples the word in the same cycle as pc.
  always_comb begin
    if (ce_i && w_run && w_addr_ok) begin
      inst_o = r_mem[addr_i[AW+1:2]];
    end else begin
      inst_o = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Self-checking bench: directed load/fetch scenarios followed by randomized
// loads, reloads, resets and fetches, all compared against a byte-stream model
// of the loader. A second instance with AW = 2 exercises the memory-full path.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   addr;
  logic [31:0]   inst;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          reload;
  logic          cpu_hold;
  logic [AW:0]   words;
  logic          addr_err;

  // small instance (AW = 2) for the full-memory case
  logic          s_ce;
  logic [31:0]   s_addr;
  logic [31:0]   s_inst;
  logic          s_valid;
  logic [7:0]    s_byte;
  logic          s_last;
  logic          s_ready;
  logic          s_reload;
  logic          s_hold;
  logic [2:0]    s_words;
  logic          s_err;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0]   m_mem   [DEPTH];
  bit            m_known [DEPTH];
  bit            m_run;
  int            m_ptr;
  int            m_words;
  bit            m_err;
  logic [7:0]    cur [$];

  always #5 clk = ~clk;

  inst_rom_loader #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ld_ready), .reload_i(reload), .cpu_hold_o(cpu_hold),
    .ld_words_o(words), .addr_err_o(addr_err)
  );

  inst_rom_loader #(.AW(2)) dut_s (
    .clk(clk), .rst(rst), .ce_i(s_ce), .addr_i(s_addr), .inst_o(s_inst),
    .ld_valid_i(s_valid), .ld_byte_i(s_byte), .ld_last_i(s_last),
    .ld_ready_o(s_ready), .reload_i(s_reload), .cpu_hold_o(s_hold),
    .ld_words_o(s_words), .addr_err_o(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return ((a >> (AW + 2)) != 32'd0) || (a[1:0] != 2'b00);
  endfunction

  task automatic model_reset();
    m_run   = 1'b0;
    m_ptr   = 0;
    m_words = 0;
    m_err   = 1'b0;
    cur.delete();
  endtask

  // Apply one rising edge worth of behaviour using the bench's own inputs.
  task automatic model_edge();
    logic [31:0] w;
    if (m_run) begin
      if (ce && addr_bad(addr)) m_err = 1'b1;
      if (reload) begin
        m_run   = 1'b0;
        m_ptr   = 0;
        m_words = 0;
        m_err   = 1'b0;
        cur.delete();
      end
    end else if (ld_valid) begin
      cur.push_back(ld_byte);
      if (cur.size() == 4 || ld_last) begin
        w = 32'h0;
        for (int i = 0; i < cur.size(); i++) w = w | (32'(cur[i]) << (24 - 8 * i));
        m_mem[m_ptr]   = w;
        m_known[m_ptr] = 1'b1;
        m_words++;
        cur.delete();
        if (ld_last || m_ptr == DEPTH - 1) m_run = 1'b1;
        else m_ptr++;
      end
    end
  endtask

  // One clock: update model at the edge, check status on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("cpu_hold", 32'(cpu_hold), 32'(!m_run));
    chk("ld_ready", 32'(ld_ready), 32'(!m_run));
    chk("ld_words", 32'(words), 32'(m_words));
    chk("addr_err", 32'(addr_err), 32'(m_err));
  endtask

  task automatic send(input logic [7:0] b, input bit last, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      ld_valid = 1'b0;
      ld_last  = 1'($urandom_range(0, 1));
      ld_byte  = 8'($urandom);
      reload   = (m_run == 1'b0) && ($urandom_range(0, 3) == 0);
      tick();
    end
    reload   = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic c,
                       input bit has_d = 1'b0, input logic [31:0] dexp = 32'h0);
    logic [31:0] exp;
    int idx;
    bit ok;
    exp  = 32'h0;
    ok   = 1'b1;
    ce   = c;
    addr = a;
    #1;
    idx = int'(a[AW+1:2]);
    if (c && m_run && !addr_bad(a)) begin
      if (m_known[idx]) exp = m_mem[idx];
      else ok = 1'b0;
    end
    if (ok) chk("inst", inst, exp);
    if (has_d) chk("inst_dir", inst, dexp);
    tick();
    ce   = 1'b0;
    addr = 32'h0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ld_ready), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_words", 32'(words), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] img1 [8] = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};

  initial begin
    rst = 1'b0; ce = 1'b0; addr = 32'h0; ld_valid = 1'b0; ld_byte = 8'h0;
    ld_last = 1'b0; reload = 1'b0;
    s_ce = 1'b0; s_addr = 32'h0; s_valid = 1'b0; s_byte = 8'h0; s_last = 1'b0;
    s_reload = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", 32'(ld_ready), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_words", 32'(words), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    chk("rst_inst", inst, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // load-and-fetch
    for (int i = 0; i < 8; i++) send(img1[i], i == 7, $urandom_range(0, 2));
    chk("t1_words", 32'(words), 32'd2);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    fetch(32'h0, 1'b1, 1'b1, 32'h3401_1100);
    fetch(32'h4, 1'b1, 1'b1, 32'h3402_0020);

    // loader inputs are ignored in RUN
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_byte  = 8'($urandom);
      ld_last  = 1'($urandom_range(0, 1));
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch(32'h0, 1'b1, 1'b1, 32'h3401_1100);

    // partial last word
    do_reload();
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
    send(8'hAA, 1'b0, 1);
    send(8'hBB, 1'b1, 1);
    chk("t2_words", 32'(words), 32'd3);
    fetch(32'h8, 1'b1, 1'b1, 32'hAABB_0000);

    // enable and address errors
    fetch(32'h0, 1'b0, 1'b1, 32'h0);
    chk("t3_noerr", 32'(addr_err), 32'd0);
    fetch(32'h0000_1000, 1'b1, 1'b1, 32'h0);
    chk("t3_err_range", 32'(addr_err), 32'd1);
    do_reload();
    chk("t3_err_clr", 32'(addr_err), 32'd0);
    for (int i = 0; i < 4; i++) send(img1[i], i == 3, 0);
    fetch(32'h2, 1'b1, 1'b1, 32'h0);
    chk("t3_err_mis", 32'(addr_err), 32'd1);

    // reset mid-load: word 0 written, word 1 partial
    do_reload();
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0, 0);
    do_reset();
    tick();
    send(8'h5A, 1'b1, 0);
    fetch(32'h0, 1'b1, 1'b1, 32'h5A00_0000);
    fetch(32'h4, 1'b1);

    // randomized loads, reloads, resets and fetches
    for (int it = 0; it < 25; it++) begin
      int n;
      logic [31:0] a;
      int r;
      n = $urandom_range(1, 14);
      if (m_run) do_reload();
      for (int k = 0; k < n; k++) begin
        if (k == n / 2 && k > 0 && $urandom_range(0, 5) == 0) begin
          do_reset();
          tick();
        end
        send(8'($urandom), k == n - 1, $urandom_range(0, 2));
      end
      for (int f = 0; f < 6; f++) begin
        r = $urandom_range(0, 9);
        if (r == 0) a = 32'h0000_1000 << $urandom_range(0, 19);
        else if (r == 1) a = (32'($urandom_range(0, 4)) << 2) | 32'($urandom_range(1, 3));
        else a = 32'($urandom_range(0, m_words + 1)) << 2;
        fetch(a, 1'($urandom_range(0, 4) != 0));
      end
    end

    // full memory with AW = 2: 16 bytes, no last flag
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_byte  = 8'(8'h10 + i);
      @(posedge clk);
      @(negedge clk);
      if (i == 14) chk("full_hold15", 32'(s_hold), 32'd1);
    end
    chk("full_hold", 32'(s_hold), 32'd0);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_words", 32'(s_words), 32'd4);
    for (int i = 0; i < 4; i++) begin
      s_byte = 8'hEE;
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("full_words2", 32'(s_words), 32'd4);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b0;
      b0 = 8'(8'h10 + 4 * k);
      s_ce   = 1'b1;
      s_addr = 32'(k) << 2;
      #1;
      chk("full_word", s_inst, {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
      @(negedge clk);
    end
    s_ce = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
